// File: rtl/dcpu16_seq_if.sv
// Fetch, address-block and condition handshake bundle for dcpu16_seq.
// The slave side is the sequencer; the master side is fetch/ALU/address block.
interface dcpu16_seq_if #(
    parameter int unsigned OPW = 4,
    parameter int unsigned OW  = 6,
    parameter int unsigned RAW = 3
);
    localparam int unsigned DW = OPW + 2 * OW;

    logic [DW-1:0]  fs_dti;
    logic           fs_ena;
    logic           fs_ack;
    logic           ab_ena;
    logic           ab_ack;
    logic           cnd_vld;
    logic           cnd;

    logic           ena;
    logic [DW-1:0]  ireg;
    logic [1:0]     st;
    logic [OW-1:0]  ea;
    logic [RAW-1:0] rra;
    logic [OPW-1:0] opc;
    logic [RAW-1:0] rwa;
    logic           rwe;
    logic           skp;
    logic           drp;

    modport master (
        output fs_dti, fs_ena, fs_ack, ab_ena, ab_ack, cnd_vld, cnd,
        input  ena, ireg, st, ea, rra, opc, rwa, rwe, skp, drp
    );

    modport slave (
        input  fs_dti, fs_ena, fs_ack, ab_ena, ab_ack, cnd_vld, cnd,
        output ena, ireg, st, ea, rra, opc, rwa, rwe, skp, drp
    );
endinterface

// File: rtl/dcpu16_seq.sv
// DCPU16 control/decode sequencer: FET/OPA/OPB/DROP state machine with
// conditional-skip resolution and a WBD-deep register write-back pipe.
module dcpu16_seq #(
    parameter int unsigned OPW = 4,
    parameter int unsigned OW  = 6,
    parameter int unsigned RAW = 3,
    parameter int unsigned WBD = 4
) (
    input  logic        clk,
    input  logic        rst,
    dcpu16_seq_if.slave bus
);
    localparam int unsigned DW  = OPW + 2 * OW;
    localparam int unsigned WBW = RAW + 1;

    localparam logic [OPW-1:0]    OPC_IF  = OPW'(2 ** OPW - 4);
    localparam logic [OW-1:0]     NW_NXT  = OW'(2 ** (OW - 1) - 2);
    localparam logic [OW-1:0]     NW_LIT  = OW'(2 ** (OW - 1) - 1);
    localparam logic [OW-RAW-1:0] MODE_IX = (OW - RAW)'(2);

    typedef enum logic [1:0] {
        FET  = 2'd0,
        OPA  = 2'd1,
        OPB  = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          st_q, st_d;
    logic [DW-1:0]   ireg_q, ireg_d;
    logic [OW-1:0]   ea_q, ea_d;
    logic [RAW-1:0]  rra_q, rra_d;
    logic [OPW-1:0]  opc_q, opc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            skp_q, skp_d;
    logic            drp_q;
    logic [RAW-1:0]  rwa_q;
    logic            rwe_q;
    logic [WBW-1:0]  wb_in;
    logic [WBD-1:0][WBW-1:0] wb_pipe;

    logic            ena;
    logic            skip_set;
    logic            we;
    logic [1:0]      n_drop;
    logic [OPW-1:0]  dec_o;
    logic [OW-1:0]   dec_a, dec_b, fet_a, fet_b;

    // Operand consumes a following word: indexed, next-word or literal-next mode.
    function automatic logic nw(input logic [OW-1:0] x);
        nw = (x[OW-1:RAW] == MODE_IX) || (x == NW_NXT) || (x == NW_LIT);
    endfunction

    assign ena      = (bus.fs_ena ~^ bus.fs_ack) & (bus.ab_ena ~^ bus.ab_ack);
    assign skip_set = bus.cnd_vld & ~bus.cnd;

    assign dec_o = ireg_q[OPW-1:0];
    assign dec_a = ireg_q[OPW+OW-1:OPW];
    assign dec_b = ireg_q[OPW+2*OW-1:OPW+OW];
    assign fet_a = bus.fs_dti[OPW+OW-1:OPW];
    assign fet_b = bus.fs_dti[OPW+2*OW-1:OPW+OW];

    assign n_drop = {1'b0, nw(fet_a)} + {1'b0, nw(fet_b)};
    assign we     = (dec_a[OW-1:RAW] == '0) && (dec_o != '0) && (dec_o < OPC_IF);

    // Next-state and datapath updates; everything but skp holds while ena=0.
    always_comb begin
        st_d   = st_q;
        ireg_d = ireg_q;
        ea_d   = ea_q;
        rra_d  = rra_q;
        opc_d  = opc_q;
        cnt_d  = cnt_q;
        skp_d  = skp_q | skip_set;
        wb_in  = '0;
        if (ena) begin
            unique case (st_q)
                FET: begin
                    // A failing condition on this very edge skips the word being sampled.
                    if (skp_q | skip_set) begin
                        ireg_d = '0;
                        skp_d  = 1'b0;
                        cnt_d  = n_drop;
                        st_d   = (n_drop != 2'd0) ? DROP : FET;
                    end else begin
                        ireg_d = bus.fs_dti;
                        st_d   = OPA;
                    end
                end
                OPA: begin
                    ea_d  = dec_a;
                    rra_d = dec_a[RAW-1:0];
                    st_d  = OPB;
                end
                OPB: begin
                    ea_d  = dec_b;
                    rra_d = dec_b[RAW-1:0];
                    opc_d = dec_o;
                    wb_in = {dec_a[RAW-1:0], we};
                    st_d  = FET;
                end
                DROP: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) st_d = FET;
                end
                default: st_d = FET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= FET;
            ireg_q <= '0;
            ea_q   <= '0;
            rra_q  <= '0;
            opc_q  <= '0;
            cnt_q  <= '0;
            skp_q  <= 1'b0;
            drp_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            ireg_q <= ireg_d;
            ea_q   <= ea_d;
            rra_q  <= rra_d;
            opc_q  <= opc_d;
            cnt_q  <= cnt_d;
            skp_q  <= skp_d;
            drp_q  <= (st_d == DROP);
        end
    end

    // Write-back delay line; the output register adds the final enabled edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_pipe <= '0;
            rwa_q   <= '0;
            rwe_q   <= 1'b0;
        end else if (ena) begin
            wb_pipe[0] <= wb_in;
            for (int i = 1; i < int'(WBD); i++) begin
                wb_pipe[i] <= wb_pipe[i-1];
            end
            {rwa_q, rwe_q} <= wb_pipe[WBD-1];
        end
    end

    assign bus.ena  = ena;
    assign bus.ireg = ireg_q;
    assign bus.st   = st_q;
    assign bus.ea   = ea_q;
    assign bus.rra  = rra_q;
    assign bus.opc  = opc_q;
    assign bus.rwa  = rwa_q;
    assign bus.rwe  = rwe_q;
    assign bus.skp  = skp_q;
    assign bus.drp  = drp_q;
endmodule
